// File: rtl/kb_ascii.sv
// kb_ascii: pops PS/2 set-2 make codes from an upstream FIFO, maps them to
// ASCII and presents each character with a valid/ready handshake.
// Optional caps-lock support is enabled by defining CAPS_LOCK_EN; when it is
// undefined caps_on is tied low and code 0x58 counts as unmapped.
module kb_ascii #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [7:0]        rd_data,
    output logic              rd_fifo,
    output logic [7:0]        ascii_data,
    output logic              ascii_valid,
    input  logic              ascii_ready,
    output logic              caps_on,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        code_q, code_d;
    logic [7:0]        ascii_data_q, ascii_data_d;
    logic              ascii_valid_q, ascii_valid_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              caps_cur;
    logic              caps_key;
    logic              is_mapped;
    logic              is_letter;
    logic [7:0]        lower_char;

`ifdef CAPS_LOCK_EN
    logic caps_q, caps_d;
    assign caps_cur = caps_q;
    assign caps_key = (code_q == 8'h58);
`else
    assign caps_cur = 1'b0;
    assign caps_key = 1'b0;
`endif

    // Decode the latched scan code to its lowercase / unshifted character
    always_comb begin
        is_mapped  = 1'b1;
        is_letter  = 1'b1;
        lower_char = 8'h00;
        case (code_q)
            8'h1C: lower_char = 8'h61; // a
            8'h32: lower_char = 8'h62; // b
            8'h21: lower_char = 8'h63; // c
            8'h23: lower_char = 8'h64; // d
            8'h24: lower_char = 8'h65; // e
            8'h2B: lower_char = 8'h66; // f
            8'h34: lower_char = 8'h67; // g
            8'h33: lower_char = 8'h68; // h
            8'h43: lower_char = 8'h69; // i
            8'h3B: lower_char = 8'h6A; // j
            8'h42: lower_char = 8'h6B; // k
            8'h4B: lower_char = 8'h6C; // l
            8'h3A: lower_char = 8'h6D; // m
            8'h31: lower_char = 8'h6E; // n
            8'h44: lower_char = 8'h6F; // o
            8'h4D: lower_char = 8'h70; // p
            8'h15: lower_char = 8'h71; // q
            8'h2D: lower_char = 8'h72; // r
            8'h1B: lower_char = 8'h73; // s
            8'h2C: lower_char = 8'h74; // t
            8'h3C: lower_char = 8'h75; // u
            8'h2A: lower_char = 8'h76; // v
            8'h1D: lower_char = 8'h77; // w
            8'h22: lower_char = 8'h78; // x
            8'h35: lower_char = 8'h79; // y
            8'h1A: lower_char = 8'h7A; // z
            8'h45: begin is_letter = 1'b0; lower_char = 8'h30; end
            8'h16: begin is_letter = 1'b0; lower_char = 8'h31; end
            8'h1E: begin is_letter = 1'b0; lower_char = 8'h32; end
            8'h26: begin is_letter = 1'b0; lower_char = 8'h33; end
            8'h25: begin is_letter = 1'b0; lower_char = 8'h34; end
            8'h2E: begin is_letter = 1'b0; lower_char = 8'h35; end
            8'h36: begin is_letter = 1'b0; lower_char = 8'h36; end
            8'h3D: begin is_letter = 1'b0; lower_char = 8'h37; end
            8'h3E: begin is_letter = 1'b0; lower_char = 8'h38; end
            8'h46: begin is_letter = 1'b0; lower_char = 8'h39; end
            8'h29: begin is_letter = 1'b0; lower_char = 8'h20; end // space
            8'h5A: begin is_letter = 1'b0; lower_char = 8'h0D; end // enter
            8'h66: begin is_letter = 1'b0; lower_char = 8'h08; end // backspace
            default: begin
                is_mapped = 1'b0;
                is_letter = 1'b0;
            end
        endcase
    end

    // Next-state and pop strobe; reset overrides the pop combinationally
    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        ascii_data_d  = ascii_data_q;
        ascii_valid_d = ascii_valid_q;
        drop_cnt_d    = drop_cnt_q;
`ifdef CAPS_LOCK_EN
        caps_d        = caps_q;
`endif
        rd_fifo       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_fifo = 1'b1;
                    code_d  = rd_data;
                    state_d = MAP;
                end
            end
            MAP: begin
                state_d = IDLE;
                if (caps_key) begin
`ifdef CAPS_LOCK_EN
                    caps_d = ~caps_q;
`endif
                end else if (is_mapped) begin
                    // Uppercase is the lowercase letter with bit 5 cleared
                    ascii_data_d  = (is_letter && caps_cur) ? (lower_char & 8'hDF) : lower_char;
                    ascii_valid_d = 1'b1;
                    state_d       = HOLD;
                end else if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
            HOLD: begin
                if (ascii_ready) begin
                    ascii_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            rd_fifo = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            code_q        <= 8'h00;
            ascii_data_q  <= 8'h00;
            ascii_valid_q <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            ascii_data_q  <= ascii_data_d;
            ascii_valid_q <= ascii_valid_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef CAPS_LOCK_EN
    // Caps-lock toggle register
    always_ff @(posedge clk) begin
        if (rst) begin
            caps_q <= 1'b0;
        end else begin
            caps_q <= caps_d;
        end
    end
`endif

    assign ascii_data  = ascii_data_q;
    assign ascii_valid = ascii_valid_q;
    assign drop_cnt    = drop_cnt_q;
    assign caps_on     = caps_cur;

endmodule

// File: doc/kb_ascii.md
KB_ASCII -- requirements
Module: kb_ascii

Interface
REQ-001 The block SHALL have parameter DROP_W, default 8, giving the width of the unmapped-code counter.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port fifo_empty  input  1  high when the upstream key-code FIFO holds no entry.
REQ-005 The block SHALL have port rd_data  input  8  FIFO head scan code, valid whenever fifo_empty is low.
REQ-006 The block SHALL have port rd_fifo  output  1  one-cycle pop strobe to the FIFO.
REQ-007 The block SHALL have port ascii_data  output  8  mapped ASCII character.
REQ-008 The block SHALL have port ascii_valid  output  1  ascii_data is valid and held.
REQ-009 The block SHALL have port ascii_ready  input  1  consumer accepts the character.
REQ-010 The block SHALL have port caps_on  output  1  current caps-lock state.
REQ-011 The block SHALL have port drop_cnt  output  DROP_W  count of unmapped codes discarded.

Function
REQ-012 The FSM SHALL have states IDLE, MAP and HOLD.
REQ-013 In IDLE with fifo_empty low, the block SHALL assert rd_fifo combinationally for exactly that cycle, latch rd_data into a code register and go to MAP.
REQ-014 rd_fifo SHALL never be asserted outside IDLE or while fifo_empty is high.
REQ-015 In MAP, a mappable code SHALL register ascii_data and set ascii_valid, then go to HOLD, so ascii_valid rises two cycles after the pop cycle.
REQ-016 The map SHALL cover set-2 codes for a-z and 0-9, space (0x29 -> 0x20), enter (0x5A -> 0x0D) and backspace (0x66 -> 0x08).
REQ-017 Letter codes SHALL be: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
REQ-018 Digit codes SHALL be: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
REQ-019 Letters SHALL map to lowercase (0x61-0x7A) when caps_on is 0 and to uppercase (0x41-0x5A) when caps_on is 1; non-letters SHALL ignore caps_on.
REQ-020 In MAP, an unmapped code SHALL increment drop_cnt, produce no output and return to IDLE.
REQ-021 drop_cnt SHALL saturate at all-ones and never wrap.
REQ-022 In HOLD, ascii_data and ascii_valid SHALL stay stable until a cycle with ascii_ready high; on that edge ascii_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-023 No FIFO pop SHALL occur while in MAP or HOLD, so backpressure leaves codes in the FIFO.
REQ-024 ascii_ready high outside HOLD SHALL have no effect.
REQ-025 Peak throughput SHALL be one character per three cycles with ascii_ready tied high.

Reset
REQ-026 While rst is high, the state SHALL be IDLE and rd_fifo SHALL be 0.
REQ-027 While rst is high, ascii_data, ascii_valid, caps_on and drop_cnt SHALL all be 0.
REQ-028 rst SHALL take priority over every other input in every state, including mid-HOLD, and the in-flight character SHALL be discarded.
REQ-029 The first pop after reset SHALL occur no earlier than the first cycle with rst low.

Configuration
REQ-030 With CAPS_LOCK_EN defined, scan code 0x58 in MAP SHALL toggle caps_on, produce no output, leave drop_cnt unchanged and return to IDLE.
REQ-031 Without CAPS_LOCK_EN, caps_on SHALL be constant 0, 0x58 SHALL be treated as unmapped and no caps register SHALL be synthesised.

Verification
REQ-032 The bench SHALL push 0x1C with ascii_ready high and check rd_fifo pulses one cycle, then ascii_valid rises two cycles later with ascii_data = 0x61, held one cycle.
REQ-033 The bench SHALL push 0x16, 0x29, 0x5A with ascii_ready high and check the output sequence is 0x31, 0x20, 0x0D, with no pop during MAP or HOLD.
REQ-034 The bench SHALL hold ascii_ready low for 10 cycles after 0x32 with three codes queued and check ascii_data = 0x62 is stable, no rd_fifo, and the remaining codes are delivered in order after release.
REQ-035 With CAPS_LOCK_EN, the bench SHALL push 0x58 then 0x1A and check caps_on = 1 and output 0x5A; a further 0x58 then 0x1A SHALL give caps_on = 0 and output 0x7A.
REQ-036 The bench SHALL push 300 codes of 0x07 and check no ascii_valid and drop_cnt saturates at 0xFF.
REQ-037 The bench SHALL assert rst during HOLD and check that the next cycle has ascii_valid 0, drop_cnt 0, caps_on 0 and state IDLE, and that the next FIFO entry pops normally.
